osc_scan_ctrl: RTL and testbench

Sequencing controller for the `combLogic` oscillation-check datapath. It steps the 8 primary inputs through every vector from 0 to 2^VEC_W−1, holds each vector for a programmable settle window, and samples `OscFlag`. It then reports how many vectors cause oscillation and the first such vector. It sits between the test/control layer (start/abort/done handshake) and the combinational loop under analysis.

---
 rtl/osc_scan_ctrl.sv | 118 +++++++++++
 tb/tb_osc_scan_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/osc_scan_ctrl.sv
// Scan controller: walks every input vector, settles, samples OscFlag, reports count/first hit.
// Optional macro OSC_SCAN_HALT_EN stops the scan at the first oscillating vector.
module osc_scan_ctrl #(
  parameter int VEC_W      = 8,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = VEC_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             osc_flag,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] osc_count,
  output logic [VEC_W-1:0] first_osc_vec,
  output logic             first_osc_valid
);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [SW-1:0]    r_settle;
  logic [VEC_W-1:0] r_vec;
  logic [CNT_W-1:0] r_osc_cnt;
  logic [VEC_W-1:0] r_first;
  logic             r_first_vld;
  logic             r_aborted;
  logic             w_last_settle;
  logic             w_halt;
  logic             w_end_scan;

  assign w_last_settle = (r_settle == SW'(SETTLE_CYC - 1));
`ifdef OSC_SCAN_HALT_EN
  assign w_halt = osc_flag;
`else
  assign w_halt = 1'b0;
`endif
  assign w_end_scan = (&r_vec) | w_halt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: begin
        if (abort)              w_next = S_DONE;
        else if (w_last_settle) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort || w_end_scan) w_next = S_DONE;
        else                     w_next = S_SETTLE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle    <= '0;
      r_vec       <= '0;
      r_osc_cnt   <= '0;
      r_first     <= '0;
      r_first_vld <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_settle    <= '0;
          r_vec       <= '0;
          r_osc_cnt   <= '0;
          r_first     <= '0;
          r_first_vld <= 1'b0;
          r_aborted   <= 1'b0;
        end
        S_SETTLE: begin
          r_settle <= r_settle + 1'b1;
          if (abort) r_aborted <= 1'b1;
        end
        S_SAMPLE: begin
          // an abort discards this cycle's sample entirely
          if (abort) begin
            r_aborted <= 1'b1;
          end else begin
            if (osc_flag) begin
              if (r_osc_cnt != '1) r_osc_cnt <= r_osc_cnt + 1'b1;
              if (!r_first_vld) begin
                r_first     <= r_vec;
                r_first_vld <= 1'b1;
              end
            end
            if (!w_end_scan) begin
              r_vec    <= r_vec + 1'b1;
              r_settle <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign vec_out         = r_vec;
  assign busy            = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done            = (r_state == S_DONE);
  assign aborted         = r_aborted;
  assign osc_count       = r_osc_cnt;
  assign first_osc_vec   = r_first;
  assign first_osc_valid = r_first_vld;
endmodule

// File: tb/tb_osc_scan_ctrl.sv
// Bench for osc_scan_ctrl: timing-based reference model checked every cycle plus literal scan results.
module tb_osc_scan_ctrl;
  localparam int VW = 8;
  localparam int S  = 4;
  localparam int CW = VW + 1;
`ifdef OSC_SCAN_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic osc_flag;
  logic [VW-1:0] vec_out, first_osc_vec;
  logic busy, done, aborted, first_osc_valid;
  logic [CW-1:0] osc_count;

  int mode = 0;  // 0: oscillation table, 1: never, 2: always
  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cyc = -1;
  bit started = 1'b0;

  osc_scan_ctrl #(.VEC_W(VW), .SETTLE_CYC(S), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .osc_flag(osc_flag),
    .vec_out(vec_out), .busy(busy), .done(done), .aborted(aborted),
    .osc_count(osc_count), .first_osc_vec(first_osc_vec),
    .first_osc_valid(first_osc_valid));

  always #5 clk = ~clk;

  // 11 oscillating vectors, lowest 0x4C
  function automatic bit in_tab(input logic [VW-1:0] v);
    return v inside {8'h4C, 8'h4D, 8'h5A, 8'h80, 8'h91, 8'hA3, 8'hB0, 8'hC7, 8'hE1, 8'hF0, 8'hFF};
  endfunction
  function automatic bit osc_of(input logic [VW-1:0] v, input int md);
    return (md == 2) || ((md == 0) && in_tab(v));
  endfunction

  assign osc_flag = (mode == 2) | ((mode == 0) & in_tab(vec_out));

  // Reference: time since start decides vector index and sample slot.
  bit            m_run = 0, m_done = 0, m_fv = 0, m_ab = 0;
  int            m_k = 0;
  logic [VW-1:0] m_vec = '0, m_first = '0;
  logic [CW-1:0] m_cnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_done <= 0; m_k <= 0; m_vec <= '0;
      m_cnt <= '0; m_fv <= 0; m_first <= '0; m_ab <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1; m_k <= 0; m_vec <= '0;
        m_cnt <= '0; m_fv <= 0; m_first <= '0; m_ab <= 0;
      end
    end else if (abort) begin
      m_run <= 0; m_done <= 1; m_ab <= 1;
    end else if ((m_k % (S + 1)) != S) begin
      m_k <= m_k + 1;
    end else begin
      if (osc_of(m_vec, mode)) begin
        if (m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + 1'b1;
        if (!m_fv) begin m_fv <= 1; m_first <= m_vec; end
      end
      if (m_vec == {VW{1'b1}} || (HALT && osc_of(m_vec, mode))) begin
        m_run <= 0; m_done <= 1;
      end else begin
        m_k   <= m_k + 1;
        m_vec <= VW'((m_k + 1) / (S + 1));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cyc <= cyc;

  always @(negedge clk) begin
    if (started) begin
      chk("busy", int'(busy), int'(m_run));
      chk("done", int'(done), int'(m_done));
      chk("vec_out", int'(vec_out), int'(m_vec));
      chk("aborted", int'(aborted), int'(m_ab));
      chk("osc_count", int'(osc_count), int'(m_cnt));
      chk("first_vec", int'(first_osc_vec), int'(m_first));
      chk("first_vld", int'(first_osc_valid), int'(m_fv));
    end
  end

  task automatic go(output int e0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input int e0, output int dt);
    for (int i = 0; i < 3000 && done_cyc < e0; i++) @(negedge clk);
    if (done_cyc < e0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: no done within bound after cycle %0d", e0);
      dt = -1;
    end else begin
      dt = done_cyc - e0;
    end
    @(negedge clk);
  endtask

  task automatic table_scan(input string tag, input bit bump);
    int e0, dt;
    mode = 0;
    go(e0);
    if (bump) begin
      repeat (99) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    wait_done(e0, dt);
    chk({tag, "_latency"}, dt, HALT ? 385 : 1280);
    chk({tag, "_count"}, int'(osc_count), HALT ? 1 : 11);
    chk({tag, "_first"}, int'(first_osc_vec), 'h4C);
    chk({tag, "_fvld"}, int'(first_osc_valid), 1);
    chk({tag, "_aborted"}, int'(aborted), 0);
    chk({tag, "_vec"}, int'(vec_out), HALT ? 'h4C : 'hFF);
  endtask

  initial begin
    int e0, dt;
    #1 rst = 1'b1;
    started = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vec", int'(vec_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(osc_count), 0);
    rst = 1'b0;
    abort = 1'b1; @(negedge clk); abort = 1'b0;  // abort in IDLE ignored
    chk("idle_abort", int'(busy), 0);

    table_scan("scan1", 1'b1);
    table_scan("scan2", 1'b0);

    mode = 1;
    go(e0);
    wait_done(e0, dt);
    chk("zero_latency", dt, 1280);
    chk("zero_count", int'(osc_count), 0);
    chk("zero_fvld", int'(first_osc_valid), 0);
    chk("zero_vec", int'(vec_out), 'hFF);

    mode = 2;
    go(e0);
    repeat (12) @(negedge clk);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    wait_done(e0, dt);
    chk("abort_latency", dt, HALT ? 5 : 13);
    chk("abort_flag", int'(aborted), HALT ? 0 : 1);
    chk("abort_count", int'(osc_count), HALT ? 1 : 2);
    chk("abort_first", int'(first_osc_vec), 0);

    mode = 0;
    go(e0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_vec", int'(vec_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_fvld", int'(first_osc_valid), 0);
    repeat (3) @(negedge clk);
    chk("arst_no_done", int'(done_cyc < e0), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
